// File: rtl/secuenciador_contador_pkg.sv
// Shared definitions for the counter command sequencer: counter mode codes,
// sequencer states and the saturating rco accumulator helper.
package secuenciador_contador_pkg;

  localparam logic [1:0] MODE_UP    = 2'b00;
  localparam logic [1:0] MODE_DOWN  = 2'b01;
  localparam logic [1:0] MODE_DOWN3 = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic inc);
    return (inc && value != 4'hF) ? value + 4'd1 : value;
  endfunction

endpackage

// File: rtl/sec_cmd_fifo.sv
// Synchronous command FIFO with a synchronous flush; one spare pointer bit
// distinguishes full from empty.
module sec_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Flush wins over a same-cycle push or pop so nothing survives an abort.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/secuenciador_contador.sv
// Command sequencer for a 4-mode counter: queues (mode, D, length) commands and
// drives the counter enable for length+1 cycles, then reports final Q and rco count.
module secuenciador_contador
  import secuenciador_contador_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cnt_enable,
  output logic [1:0]       cnt_mode,
  output logic [WIDTH-1:0] cnt_D,
  input  logic [WIDTH-1:0] cnt_Q,
  input  logic             cnt_rco,
  input  logic             cnt_load,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] done_q,
  output logic [3:0]       rco_cnt,
  output logic             proto_err
);

  localparam int DW = 2 + WIDTH + LEN_W;

  state_t           state;
  logic [LEN_W-1:0] run_cnt;
  logic             first_run;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [DW-1:0]    fifo_dout;
  logic [1:0]       pop_mode;
  logic [WIDTH-1:0] pop_data;
  logic [LEN_W-1:0] pop_len;

  assign cmd_ready = !fifo_full && !reset;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = !abort && !fifo_empty && (state == ST_IDLE || state == ST_DRAIN);
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  assign pop_mode = fifo_dout[DW-1 -: 2];
  assign pop_data = fifo_dout[LEN_W +: WIDTH];
  assign pop_len  = fifo_dout[LEN_W-1:0];

  sec_cmd_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (abort),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({cmd_mode, cmd_data, cmd_len}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The first RUN cycle still shows the counter before any enabled edge, so its
  // rco is not counted; a pop at the end of the case overrides the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      run_cnt    <= '0;
      first_run  <= 1'b0;
      cnt_enable <= 1'b0;
      cnt_mode   <= 2'b00;
      cnt_D      <= '0;
      done       <= 1'b0;
      done_q     <= '0;
      rco_cnt    <= 4'd0;
      proto_err  <= 1'b0;
    end else if (abort) begin
      state      <= ST_IDLE;
      cnt_enable <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cnt_enable <= 1'b0;
        end
        ST_RUN: begin
          first_run <= 1'b0;
          if (!first_run) begin
            rco_cnt <= sat_inc(rco_cnt, cnt_rco);
          end
          if (run_cnt == '0) begin
            state      <= ST_DRAIN;
            cnt_enable <= 1'b0;
            done       <= 1'b1;
          end else begin
            run_cnt <= run_cnt - LEN_W'(1);
          end
        end
        ST_DRAIN: begin
          done_q  <= cnt_Q;
          state   <= ST_IDLE;
          rco_cnt <= sat_inc(rco_cnt, cnt_rco);
          if (cnt_mode == MODE_LOAD && !cnt_load) begin
            proto_err <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (fifo_pop) begin
        state      <= ST_RUN;
        cnt_enable <= 1'b1;
        cnt_mode   <= pop_mode;
        cnt_D      <= pop_data;
        run_cnt    <= pop_len;
        first_run  <= 1'b1;
        rco_cnt    <= 4'd0;
      end
    end
  end

endmodule
